// File: rtl/ariane_pkg.sv
// ariane_pkg: shared issue/execute types for the competition core.
//   TRANS_ID_BITS  width of a transaction ID carried on fu_data_t.
//   issue_fu_e     functional-unit class selected at issue.
//   fu_data_t      operator/operand bundle driven to the execute stage.
package ariane_pkg;

  localparam int unsigned TRANS_ID_BITS = 3;
  localparam int unsigned XLEN          = 32;
  localparam int unsigned NR_WB_PORTS   = 4;  // FLU, load, store, FPU

  typedef enum logic [2:0] {
    ALU    = 3'd0,
    BRANCH = 3'd1,
    CSR    = 3'd2,
    MULT   = 3'd3,
    LSU    = 3'd4,
    FPU    = 3'd5
  } issue_fu_e;

  typedef struct packed {
    logic [3:0]               operation;
    logic [XLEN-1:0]          operand_a;
    logic [XLEN-1:0]          operand_b;
    logic [XLEN-1:0]          imm;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } fu_data_t;

  // Classes whose results come back on the shared FLU writeback port.
  function automatic logic is_flu_class(issue_fu_e fu);
    return fu inside {ALU, BRANCH, CSR, MULT};
  endfunction

  // Classes that would collide with a MULT result returning two cycles later.
  function automatic logic is_single_cycle_flu(issue_fu_e fu);
    return fu inside {ALU, BRANCH, CSR};
  endfunction

endpackage

// File: rtl/issue_inflight_table.sv
// issue_inflight_table: in-order table of issued transaction IDs.
//   clk_i, rst_ni     clock, async active-low reset
//   flush_i           clears every entry, both pointers and the count
//   alloc_i/alloc_fu_i write {valid, !done, fu} at the tail; alloc_id_o is its ID
//   full_o            count == NrEntries
//   wb_valid_i/wb_id_i four writeback ports, each marks its ID done
//   pop_i             retire the head when it is valid and done
//   head_ready_o, head_id_o, head_fu_o  head entry state for the committer
module issue_inflight_table
  import ariane_pkg::*;
#(
  parameter int unsigned NrEntries = 8
) (
  input  logic                                        clk_i,
  input  logic                                        rst_ni,
  input  logic                                        flush_i,
  input  logic                                        alloc_i,
  input  issue_fu_e                                   alloc_fu_i,
  output logic [TRANS_ID_BITS-1:0]                    alloc_id_o,
  output logic                                        full_o,
  input  logic [NR_WB_PORTS-1:0]                      wb_valid_i,
  input  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]   wb_id_i,
  input  logic                                        pop_i,
  output logic                                        head_ready_o,
  output logic [TRANS_ID_BITS-1:0]                    head_id_o,
  output issue_fu_e                                   head_fu_o
);

  localparam int unsigned PtrW  = $clog2(NrEntries);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned NrIds = 2 ** TRANS_ID_BITS;

  logic [NrEntries-1:0] valid_q, valid_d;
  logic [NrEntries-1:0] done_q, done_d;
  issue_fu_e            fu_q [NrEntries];
  logic [PtrW-1:0]      head_q, tail_q;
  logic [CntW-1:0]      count_q;
  logic [NrIds-1:0]     wb_hit;
  logic                 pop_fire;

  assign full_o       = (count_q == CntW'(NrEntries));
  assign alloc_id_o   = TRANS_ID_BITS'(tail_q);
  assign head_id_o    = TRANS_ID_BITS'(head_q);
  assign head_fu_o    = fu_q[head_q];
  assign head_ready_o = valid_q[head_q] & done_q[head_q];
  assign pop_fire     = pop_i & head_ready_o;

  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    wb_hit = '0;
    for (int p = 0; p < NR_WB_PORTS; p++) begin
      if (wb_valid_i[p]) wb_hit[wb_id_i[p]] = 1'b1;
    end
  end

  // Writebacks only mark entries that are currently in flight.
  always_comb begin
    valid_d = valid_q;
    done_d  = done_q | (wb_hit[NrEntries-1:0] & valid_q);
    if (pop_fire) begin
      valid_d[head_q] = 1'b0;
      done_d[head_q]  = 1'b0;
    end
    if (alloc_i) begin
      valid_d[tail_q] = 1'b1;
      done_d[tail_q]  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; combinational next-state uses blocking.
  // NOTE: the fu array is reset along with the flags so commit_fu_o reads ALU out of reset; the table is small.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < NrEntries; i++) fu_q[i] <= ALU;
    end else if (flush_i) begin
      valid_q <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      if (alloc_i) begin
        fu_q[tail_q] <= alloc_fu_i;
        tail_q       <= tail_q + PtrW'(1);
      end
      if (pop_fire) head_q <= head_q + PtrW'(1);
      count_q <= count_q + CntW'(alloc_i) - CntW'(pop_fire);
    end
  end

endmodule

// File: rtl/issue_sequencer.sv
// issue_sequencer: accepts decoded instructions, tags them with a transaction
// ID, issues them one cycle later on fu_data_o with a one-hot unit strobe, and
// tracks them in order until written back and acknowledged by the committer.
//   instr_valid_i/instr_ready_o/instr_fu_i/instr_data_i  decoder handshake
//   fu_data_o, *_valid_o                                 issue to execute stage
//   flu/lsu/fpu_ready_i                                  unit readiness
//   flu/load/store/fpu_valid_i, *_trans_id_i             writebacks
//   commit_valid_o/commit_ack_i/commit_trans_id_o/commit_fu_o  retirement
// Build option: define ISSUE_SEQ_FPU_EN to enable FPU issue and writeback;
// otherwise FPU instructions are never accepted and fpu_valid_o is tied 0.
module issue_sequencer
  import ariane_pkg::*;
#(
  parameter int unsigned NrEntries = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     instr_valid_i,
  output logic                     instr_ready_o,
  input  issue_fu_e                instr_fu_i,
  input  fu_data_t                 instr_data_i,
  output fu_data_t                 fu_data_o,
  output logic                     alu_valid_o,
  output logic                     branch_valid_o,
  output logic                     csr_valid_o,
  output logic                     mult_valid_o,
  output logic                     lsu_valid_o,
  output logic                     fpu_valid_o,
  input  logic                     flu_ready_i,
  input  logic                     lsu_ready_i,
  input  logic                     fpu_ready_i,
  input  logic                     flu_valid_i,
  input  logic                     load_valid_i,
  input  logic                     store_valid_i,
  input  logic                     fpu_valid_i,
  input  logic [TRANS_ID_BITS-1:0] flu_trans_id_i,
  input  logic [TRANS_ID_BITS-1:0] load_trans_id_i,
  input  logic [TRANS_ID_BITS-1:0] store_trans_id_i,
  input  logic [TRANS_ID_BITS-1:0] fpu_trans_id_i,
  output logic                     commit_valid_o,
  input  logic                     commit_ack_i,
  output logic [TRANS_ID_BITS-1:0] commit_trans_id_o,
  output issue_fu_e                commit_fu_o
);

  logic                                      unit_ready;
  logic                                      mult_blocked;
  logic                                      accept;
  logic                                      full;
  logic [TRANS_ID_BITS-1:0]                  alloc_id;
  fu_data_t                                  accepted_data;
  logic                                      mult_block_q;
  logic                                      issue_valid_q;
  issue_fu_e                                 issue_fu_q;
  fu_data_t                                  issue_data_q;
  logic                                      fpu_wb_valid;
  logic [TRANS_ID_BITS-1:0]                  fpu_wb_id;
  logic [NR_WB_PORTS-1:0]                    wb_valid;
  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0] wb_id;

  always_comb begin
    unit_ready = 1'b0;
    if (is_flu_class(instr_fu_i)) unit_ready = flu_ready_i;
    else if (instr_fu_i == LSU)   unit_ready = lsu_ready_i;
`ifdef ISSUE_SEQ_FPU_EN
    else if (instr_fu_i == FPU)   unit_ready = fpu_ready_i;
`endif
  end

  // A MULT result lands on the FLU port two cycles after acceptance, the same
  // cycle a single-cycle FLU op accepted one cycle later would write back.
  assign mult_blocked  = mult_block_q & is_single_cycle_flu(instr_fu_i);
  assign instr_ready_o = ~flush_i & ~full & unit_ready & ~mult_blocked;
  assign accept        = instr_valid_i & instr_ready_o;

  always_comb begin
    accepted_data          = instr_data_i;
    accepted_data.trans_id = alloc_id;
  end

  // The issue register holds zeros when idle so fu_data_o is silent.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mult_block_q  <= 1'b0;
      issue_valid_q <= 1'b0;
      issue_fu_q    <= ALU;
      issue_data_q  <= '0;
    end else if (flush_i) begin
      mult_block_q  <= 1'b0;
      issue_valid_q <= 1'b0;
      issue_fu_q    <= ALU;
      issue_data_q  <= '0;
    end else begin
      mult_block_q  <= accept & (instr_fu_i == MULT);
      issue_valid_q <= accept;
      issue_fu_q    <= accept ? instr_fu_i : ALU;
      issue_data_q  <= accept ? accepted_data : '0;
    end
  end

  assign fu_data_o      = issue_data_q;
  assign alu_valid_o    = issue_valid_q & (issue_fu_q == ALU);
  assign branch_valid_o = issue_valid_q & (issue_fu_q == BRANCH);
  assign csr_valid_o    = issue_valid_q & (issue_fu_q == CSR);
  assign mult_valid_o   = issue_valid_q & (issue_fu_q == MULT);
  assign lsu_valid_o    = issue_valid_q & (issue_fu_q == LSU);

`ifdef ISSUE_SEQ_FPU_EN
  assign fpu_valid_o  = issue_valid_q & (issue_fu_q == FPU);
  assign fpu_wb_valid = fpu_valid_i;
  assign fpu_wb_id    = fpu_trans_id_i;
`else
  logic unused_fpu;
  assign unused_fpu   = ^{fpu_ready_i, fpu_valid_i, fpu_trans_id_i};
  assign fpu_valid_o  = 1'b0;
  assign fpu_wb_valid = 1'b0;
  assign fpu_wb_id    = '0;
`endif

  assign wb_valid = {fpu_wb_valid, store_valid_i, load_valid_i, flu_valid_i};
  assign wb_id    = {fpu_wb_id, store_trans_id_i, load_trans_id_i, flu_trans_id_i};

  issue_inflight_table #(
    .NrEntries (NrEntries)
  ) u_table (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flush_i      (flush_i),
    .alloc_i      (accept),
    .alloc_fu_i   (instr_fu_i),
    .alloc_id_o   (alloc_id),
    .full_o       (full),
    .wb_valid_i   (wb_valid),
    .wb_id_i      (wb_id),
    .pop_i        (commit_ack_i),
    .head_ready_o (commit_valid_o),
    .head_id_o    (commit_trans_id_o),
    .head_fu_o    (commit_fu_o)
  );

endmodule

// File: tb/tb_issue_sequencer.sv
// Self-checking bench for issue_sequencer: expected issues are queued when an
// accept is driven and compared when a strobe appears on the execute side.
module tb_issue_sequencer;
  import ariane_pkg::*;

  logic                     clk_i = 1'b0;
  logic                     rst_ni = 1'b0;
  logic                     flush_i;
  logic                     instr_valid_i;
  logic                     instr_ready_o;
  issue_fu_e                instr_fu_i;
  fu_data_t                 instr_data_i;
  fu_data_t                 fu_data_o;
  logic                     alu_valid_o, branch_valid_o, csr_valid_o;
  logic                     mult_valid_o, lsu_valid_o, fpu_valid_o;
  logic                     flu_ready_i, lsu_ready_i, fpu_ready_i;
  logic                     flu_valid_i, load_valid_i, store_valid_i, fpu_valid_i;
  logic [TRANS_ID_BITS-1:0] flu_trans_id_i, load_trans_id_i;
  logic [TRANS_ID_BITS-1:0] store_trans_id_i, fpu_trans_id_i;
  logic                     commit_valid_o;
  logic                     commit_ack_i;
  logic [TRANS_ID_BITS-1:0] commit_trans_id_o;
  issue_fu_e                commit_fu_o;

  always #5 clk_i = ~clk_i;

  issue_sequencer #(.NrEntries(8)) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .flush_i           (flush_i),
    .instr_valid_i     (instr_valid_i),
    .instr_ready_o     (instr_ready_o),
    .instr_fu_i        (instr_fu_i),
    .instr_data_i      (instr_data_i),
    .fu_data_o         (fu_data_o),
    .alu_valid_o       (alu_valid_o),
    .branch_valid_o    (branch_valid_o),
    .csr_valid_o       (csr_valid_o),
    .mult_valid_o      (mult_valid_o),
    .lsu_valid_o       (lsu_valid_o),
    .fpu_valid_o       (fpu_valid_o),
    .flu_ready_i       (flu_ready_i),
    .lsu_ready_i       (lsu_ready_i),
    .fpu_ready_i       (fpu_ready_i),
    .flu_valid_i       (flu_valid_i),
    .load_valid_i      (load_valid_i),
    .store_valid_i     (store_valid_i),
    .fpu_valid_i       (fpu_valid_i),
    .flu_trans_id_i    (flu_trans_id_i),
    .load_trans_id_i   (load_trans_id_i),
    .store_trans_id_i  (store_trans_id_i),
    .fpu_trans_id_i    (fpu_trans_id_i),
    .commit_valid_o    (commit_valid_o),
    .commit_ack_i      (commit_ack_i),
    .commit_trans_id_o (commit_trans_id_o),
    .commit_fu_o       (commit_fu_o)
  );

  typedef struct packed {
    issue_fu_e fu;
    fu_data_t  data;
  } exp_issue_t;

  exp_issue_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic fu_data_t mk_data(input int opa);
    fu_data_t d;
    d.operation = 4'(opa);
    d.operand_a = 32'(opa);
    d.operand_b = ~32'(opa);
    d.imm       = 32'(opa * 3);
    d.trans_id  = '1;  // must be overwritten by the DUT
    return d;
  endfunction

  function automatic logic [5:0] strobes();
    return {fpu_valid_o, lsu_valid_o, mult_valid_o, csr_valid_o, branch_valid_o, alu_valid_o};
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Offer one instruction that must be accepted at the next edge with ID exp_id.
  task automatic accept(input issue_fu_e fu, input int opa, input int exp_id);
    exp_issue_t e;
    instr_fu_i    = fu;
    instr_data_i  = mk_data(opa);
    instr_valid_i = 1'b1;
    #1;
    check("accept_ready", instr_ready_o, 1'b1);
    e.fu            = fu;
    e.data          = mk_data(opa);
    e.data.trans_id = TRANS_ID_BITS'(exp_id);
    exp_q.push_back(e);
    @(posedge clk_i);
    #1;
    instr_valid_i = 1'b0;
  endtask

  task automatic wb(input int port, input int id);
    case (port)
      0: begin flu_valid_i   = 1'b1; flu_trans_id_i   = TRANS_ID_BITS'(id); end
      1: begin load_valid_i  = 1'b1; load_trans_id_i  = TRANS_ID_BITS'(id); end
      2: begin store_valid_i = 1'b1; store_trans_id_i = TRANS_ID_BITS'(id); end
      default: begin fpu_valid_i = 1'b1; fpu_trans_id_i = TRANS_ID_BITS'(id); end
    endcase
    step();
    flu_valid_i = 1'b0; load_valid_i = 1'b0; store_valid_i = 1'b0; fpu_valid_i = 1'b0;
  endtask

  task automatic commit(input int id, input issue_fu_e fu);
    check("commit_valid", commit_valid_o, 1'b1);
    check("commit_id", commit_trans_id_o, TRANS_ID_BITS'(id));
    check("commit_fu", commit_fu_o, fu);
    commit_ack_i = 1'b1;
    step();
    commit_ack_i = 1'b0;
  endtask

  task automatic flush();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
  endtask

  // Execute-side monitor: every strobe must match the oldest queued issue.
  always @(negedge clk_i) begin
    logic [5:0] stb;
    exp_issue_t e;
    if (rst_ni) begin
      stb = strobes();
      if (stb != 6'd0) begin
        if (exp_q.size() == 0) begin
          check("spurious_strobe", stb, 6'd0);
        end else begin
          e = exp_q.pop_front();
          check("strobe_onehot", stb, 6'd1 << e.fu);
          check("fu_data", fu_data_o, e.data);
        end
      end else begin
        check("idle_data", fu_data_o, '0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    flush_i = 0; instr_valid_i = 0; instr_fu_i = ALU; instr_data_i = '0;
    flu_ready_i = 1; lsu_ready_i = 1; fpu_ready_i = 1;
    flu_valid_i = 0; load_valid_i = 0; store_valid_i = 0; fpu_valid_i = 0;
    flu_trans_id_i = 0; load_trans_id_i = 0; store_trans_id_i = 0; fpu_trans_id_i = 0;
    commit_ack_i = 0;

    // Reset values.
    #12;
    check("rst_strobes", strobes(), 6'd0);
    check("rst_fu_data", fu_data_o, '0);
    check("rst_commit_valid", commit_valid_o, 1'b0);
    check("rst_commit_id", commit_trans_id_o, '0);
    check("rst_commit_fu", commit_fu_o, ALU);
    check("rst_ready", instr_ready_o, 1'b1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    step();

    // Unit readiness selection.
    flu_ready_i = 0; instr_fu_i = ALU; #1;
    check("alu_not_ready", instr_ready_o, 1'b0);
    instr_fu_i = LSU; #1;
    check("lsu_ready_indep", instr_ready_o, 1'b1);
    flu_ready_i = 1;
    step();

    // Basic ALU issue, writeback, commit.
    accept(ALU, 5, 0);
    wb(0, 0);
    commit(0, ALU);
    check("commit_cleared", commit_valid_o, 1'b0);

    // MULT collision window.
    accept(MULT, 7, 1);
    instr_fu_i = ALU; instr_valid_i = 1'b1; #1;
    check("mult_block_alu", instr_ready_o, 1'b0);
    instr_fu_i = CSR; #1;
    check("mult_block_csr", instr_ready_o, 1'b0);
    instr_fu_i = ALU;
    step();
    accept(ALU, 8, 2);
    accept(MULT, 9, 3);
    accept(LSU, 10, 4);  // LSU is allowed right after a MULT
    flush();

    // Fill the table, then wrap around.
    for (int i = 0; i < 8; i++) accept(LSU, 20 + i, i);
    instr_fu_i = LSU; instr_valid_i = 1'b1; #1;
    check("full_ready", instr_ready_o, 1'b0);
    instr_valid_i = 1'b0;
    load_valid_i = 1'b1; load_trans_id_i = 0;
    store_valid_i = 1'b1; store_trans_id_i = 1;
    step();
    load_valid_i = 1'b0; store_valid_i = 1'b0;
    instr_valid_i = 1'b1; #1;
    check("full_pop_no_free", instr_ready_o, 1'b0);
    commit(0, LSU);
    instr_valid_i = 1'b0;
    commit(1, LSU);
    accept(LSU, 30, 0);
    accept(LSU, 31, 1);
    check("wrap_head_not_done", commit_valid_o, 1'b0);
    flush();

    // Out-of-order writebacks retire in order.
    accept(ALU, 40, 0);
    accept(BRANCH, 41, 1);
    accept(CSR, 42, 2);
    wb(0, 2);
    check("ooo_wait_id0", commit_valid_o, 1'b0);
    wb(0, 0);
    commit(0, ALU);
    check("ooo_wait_id1", commit_valid_o, 1'b0);
    wb(0, 1);
    commit(1, BRANCH);
    commit(2, CSR);
    check("ooo_empty", commit_valid_o, 1'b0);
    wb(0, 3);  // stale writeback to a free slot
    accept(ALU, 45, 3);
    check("stale_wb_ignored", commit_valid_o, 1'b0);
    wb(0, 3);
    commit(3, ALU);
    flush();

    // Flush with five in flight, racing accept, writeback and commit.
    for (int i = 0; i < 5; i++) accept(ALU, 50 + i, i);
    wb(0, 0);
    flush_i = 1; instr_valid_i = 1; instr_fu_i = ALU; instr_data_i = mk_data(59);
    flu_valid_i = 1; flu_trans_id_i = 1; commit_ack_i = 1;
    #1;
    check("flush_ready", instr_ready_o, 1'b0);
    @(posedge clk_i);
    #1;
    flush_i = 0; instr_valid_i = 0; flu_valid_i = 0; commit_ack_i = 0;
    check("flush_commit_valid", commit_valid_o, 1'b0);
    check("flush_strobes", strobes(), 6'd0);
    accept(ALU, 60, 0);
    wb(0, 0);
    commit(0, ALU);

    // FPU class.
`ifdef ISSUE_SEQ_FPU_EN
    accept(FPU, 70, 1);
    wb(3, 1);
    commit(1, FPU);
`else
    instr_fu_i = FPU; instr_data_i = mk_data(70); instr_valid_i = 1; fpu_ready_i = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("fpu_disabled_ready", instr_ready_o, 1'b0);
      step();
    end
    instr_valid_i = 0;
`endif

    step();
    step();
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/issue_sequencer.md
# issue_sequencer

Issue-side counterpart of the execute stage: accepts decoded instructions from the decode/rename path, assigns a transaction ID, drives the shared `fu_data` bus and exactly one per-unit valid strobe into the execute stage, and collects the FLU/load/store/FPU writebacks. An in-order in-flight table tracks every issued ID until it is written back and retired. It sits between the decoder and the execute stage, in place of a full scoreboard, for the competition core.

## Interface
Parameters:
- `NrEntries`, 8, in-flight table depth; power of two, ≤ 2**`TRANS_ID_BITS`.

Ports:
- `clk_i` in 1: clock; single clock domain.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `flush_i` in 1: pipeline flush.
- `instr_valid_i` in 1, `instr_ready_o` out 1: decoder handshake.
- `instr_fu_i` in `issue_fu_e`: target unit (ALU, BRANCH, CSR, MULT, LSU, FPU).
- `instr_data_i` in `fu_data_t`: operator/operands; the incoming `trans_id` field is ignored.
- `fu_data_o` out `fu_data_t`: to the execute stage, with `trans_id` overwritten.
- `alu_valid_o`, `branch_valid_o`, `csr_valid_o`, `mult_valid_o`, `lsu_valid_o`, `fpu_valid_o` out 1 each: one-hot issue strobes.
- `flu_ready_i`, `lsu_ready_i`, `fpu_ready_i` in 1: unit readiness.
- `flu_valid_i`, `load_valid_i`, `store_valid_i`, `fpu_valid_i` in 1: writeback valids.
- `flu_trans_id_i`, `load_trans_id_i`, `store_trans_id_i`, `fpu_trans_id_i` in `TRANS_ID_BITS`: writeback IDs.
- `commit_valid_o` out 1, `commit_ack_i` in 1: retirement handshake.
- `commit_trans_id_o` out `TRANS_ID_BITS`, `commit_fu_o` out `issue_fu_e`: head entry, used by the committer to pulse `lsu_commit` or `csr_commit`.

## Operation
- **Accept.** `instr_ready_o` = !`flush_i` & !full & unit_ready & !mult_block.
  - unit_ready is `flu_ready_i` for ALU, BRANCH, CSR and MULT; `lsu_ready_i` for LSU; `fpu_ready_i` for FPU.
  - Full is count == `NrEntries`. A same-cycle pop does not free a slot for a same-cycle accept.
- **Allocation.** On accept, the entry at the tail is written as {valid=1, done=0, fu}. Its ID is the tail pointer, zero-extended to `TRANS_ID_BITS`. The tail then increments, wrapping modulo `NrEntries`.
- **Issue register.** The accepted instruction is registered. In the next cycle `fu_data_o` carries it with `trans_id` set, and the matching strobe is high for exactly one cycle.
- **Idle outputs.** When nothing was accepted, all strobes are 0 and `fu_data_o` is all zeros. This is data silencing.
- **MULT collision.** The MULT result returns on the FLU port two cycles after acceptance. Therefore, in the cycle after a MULT is accepted, ALU, BRANCH and CSR accepts are blocked. A MULT, LSU or FPU accept in that cycle is allowed.
- **Writeback.** Up to four writebacks can arrive per cycle. Each sets done for its ID. A writeback to an invalid entry is ignored. A writeback to an entry being allocated in the same cycle cannot occur, because allocation precedes issue.
- **Commit.**
  - `commit_valid_o` = head.valid & head.done.
  - `commit_ack_i` while `commit_valid_o` is high clears the head entry and increments the head pointer.
  - `commit_ack_i` without `commit_valid_o` is ignored.
- **Count.** The count changes by +accept − pop. A simultaneous accept and pop leaves it unchanged.
- **Flush.** Flush clears all valid and done bits, the pointers, the count and the issue register. Strobes are 0 in the following cycle. Flush has priority over accept, writeback and commit in the same cycle.
- **No FSM.** State is the table, the head/tail pointers, the count, the issue register and the mult_block flag.

## Timing
- Accept to strobe: 1 cycle. Writeback to `commit_valid_o`: 1 cycle, because done is registered.
- `instr_ready_o` and `commit_valid_o` are combinational from state and the ready inputs. There is no combinational path from `instr_valid_i`.
- Reset values:
  - All strobes 0, `fu_data_o` 0, `instr_ready_o` 1 once the ready inputs are high.
  - `commit_valid_o` 0, `commit_trans_id_o` 0, `commit_fu_o` ALU.
  - Pointers 0, count 0, mult_block 0.
- Reset asserted mid-operation discards all in-flight state immediately, with no drain.

## Configuration
- `ISSUE_SEQ_FPU_EN` defined: FPU-class instructions are accepted under `fpu_ready_i`, and FPU writebacks set done.
- Undefined:
  - `fpu_valid_o` is tied 0, and `fpu_ready_i`, `fpu_valid_i` and `fpu_trans_id_i` are ignored.
  - `instr_ready_o` is held 0 for FPU class. The decoder must not present FPU instructions when `FP_PRESENT`=0.

## Structure
- The `issue_fu_e` enum belongs in `ariane_pkg`, next to `fu_data_t` and `TRANS_ID_BITS`.
- Sub-module `issue_inflight_table` holds the valid/done/fu arrays, the pointers and the count, with one allocate port, four writeback ports and one pop port.
- The top level holds the accept logic, mult_block and the issue register.

## Test plan
- Reset, then an ALU accept with operand_a=5: strobe and `trans_id`=0 the next cycle. FLU writeback id 0, then `commit_valid_o`=1 with `commit_fu_o`=ALU; ack makes count 0.
- MULT accepted at cycle t, ALU offered at t+1: `instr_ready_o`=0 at t+1, the ALU is accepted at t+2, and `mult_valid_o` is high only at t+1.
- Eight LSU accepts with no writebacks: `instr_ready_o`=0 on the ninth. Writeback ids 0 and 1 with two acks, then two more accepts receive ids 0 and 1 (wrap-around).
- Out-of-order writebacks: ids 2, 0, 1 arrive. `commit_valid_o` rises only after id 0, and IDs retire in the order 0, 1, 2.
- Flush with 5 in flight while accept and writeback are asserted in the same cycle: the next cycle shows count 0, all strobes 0 and `commit_valid_o`=0, and the next accept gets id 0.
- Build without `ISSUE_SEQ_FPU_EN`, FPU instruction offered: `instr_ready_o` stays 0 and `fpu_valid_o` is never 1.
